serial_frame_tx_arbiter: RTL and testbench
==========================================

Name: serial_frame_tx_arbiter

Overview:
- Shares one serial output line among four requesters using round-robin arbitration.
- Serializes the winner's frame in the format the serial port-controller receiver decodes: start bit, 2-bit port, 4-bit length, then payload.
- Sits upstream of the controller's `sin` input. It is the transmit-side sequencer and scheduler for that datapath.

Parameters:
- DATA_W, 8, payload buffer width per requester; maximum legal length.
- LEN_W, 4, length field width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  4  per-requester request level; must be held until granted.
- data_in  input  4*DATA_W  payload of requester i in bits [i*DATA_W +: DATA_W].
- len_in  input  4*LEN_W  payload length of requester i in bits [i*LEN_W +: LEN_W].
- grant  output  4  one-hot, one-cycle acknowledge to the selected requester.
- busy  output  1  high while a frame is on sout.
- cur  output  2  index of the requester last granted.
- sout  output  1  serial line; idles high.
- done  output  1  one-cycle pulse in the stop-bit cycle.
- err  output  1  one-cycle pulse when the selected request is rejected.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sout=1, grant=0, busy=0, done=0, err=0, cur=0, round-robin pointer ptr=0. Reset mid-frame aborts the frame; sout returns to 1 immediately.
- All outputs are registered and Moore-decoded from state, bit counter and latched data.
- Arbitration happens at a rising edge in IDLE with req != 0:
  - Winner is the first set bit of req scanning ptr, ptr+1, ... (mod 4).
  - Latch the winner's data_in and len_in into local registers. Inputs are ignored afterwards.
  - Set cur = winner and ptr = (winner+1) mod 4.
  - If latched len <= DATA_W: next state START.
  - Otherwise: err=1 and grant=onehot(winner) for one cycle, state stays IDLE, sout stays 1, and the next arbitration may occur at the following edge.
- States and sout value per cycle:
  - IDLE: sout=1, busy=0.
  - START (1 cycle): sout=0, busy=1, grant=onehot(winner) this cycle only.
  - ADDR (2 cycles): cur[1], then cur[0].
  - LEN (4 cycles): len[3] down to len[0].
  - DATA (L cycles, L = latched length): data[DATA_W-1] down to data[DATA_W-L]; MSB first, lower bits unused. L=0 skips DATA, going LEN to STOP.
  - STOP (1 cycle): sout=1, busy=1, done=1. Next state IDLE.
- Frame length is 8+L cycles, START through STOP. Back-to-back frames have exactly one IDLE cycle between STOP and the next START.
- req changes during a frame have no effect. A req dropped before arbitration is never granted. A requester that keeps req high after its grant competes again at the next IDLE, behind the others.
- The bit counter is internal and wide enough for max(4, DATA_W) cycles. No wrap-around is observable.

Test Plan:
- Single request: req=4'b0100, data_in[2]=8'hA5, len_in[2]=3. Required: grant=4'b0100 in the START cycle; sout over 11 cycles = 0,1,0,0,0,1,1,1,0,1,1; done high in the 11th cycle; busy high for all 11 cycles; cur=2.
- Fairness: req=4'b1111 held, all len=1. Required: START-cycle grants in order 0001, 0010, 0100, 1000, 0001, each frame 9 cycles, one IDLE cycle between frames.
- Zero length: req=4'b0010, len=0. Required: sout = 0,0,1,0,0,0,0,1 (8 cycles); done in the 8th cycle.
- Illegal length: req=4'b0001 with len=9 and req=4'b1000 with len=2, both asserted together. Required:
  - err=1 and grant=0001 for one cycle, sout stays 1.
  - Next edge selects requester 3 and its frame starts.
  - ptr afterwards = 0.
- Reset mid-frame: assert rst=0 during DATA. Required: sout=1, busy=0, grant=0 and cur=0 asynchronously. After release, req=4'b0010 is granted first, confirming ptr=0.
- Late request: requester 1 raises req while requester 0's frame is in LEN. Required: no grant until that frame's STOP; requester 1 then enters START after one IDLE cycle.

Source files
------------

// File: rtl/serial_frame_tx_arbiter.sv
// Round-robin arbiter for four requesters that serializes the winner's frame
// (start, 2-bit port, length, MSB-first payload, stop) onto one idle-high line.
module serial_frame_tx_arbiter #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic [4*LEN_W-1:0]    len_in,
    output logic [3:0]            grant,
    output logic                  busy,
    output logic [1:0]            cur,
    output logic                  sout,
    output logic                  done,
    output logic                  err
);

    localparam int MAX_CNT = (DATA_W > LEN_W) ? DATA_W : LEN_W;
    localparam int CNT_W   = $clog2(MAX_CNT);

    typedef enum logic [2:0] {IDLE, START, ADDR, LEN, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q;
    logic [1:0]          cur_q;
    logic [3:0]          grant_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_sh;

    logic [1:0]          win;
    logic [1:0]          idx;
    logic                found;
    logic [DATA_W-1:0]   data_sel;
    logic [LEN_W-1:0]    len_sel;
    logic                len_ok;
    logic                arb;

    // First requesting index at or after the round-robin pointer
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        len_sel  = '0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                data_sel = data_in[i*DATA_W +: DATA_W];
                len_sel  = len_in[i*LEN_W +: LEN_W];
            end
        end
    end

    assign len_ok = (32'(len_sel) <= 32'(DATA_W));
    assign arb    = (state_q == IDLE) && (req != 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb && len_ok) state_d = START;
            START:   state_d = ADDR;
            ADDR:    if (cnt_q == '0) state_d = LEN;
            LEN:     if (cnt_q == '0) state_d = (len_q == '0) ? STOP : DATA;
            DATA:    if (cnt_q == '0) state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control: pointer, grant/err pulses and per-field bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            cur_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            grant_q <= '0;
            err_q   <= 1'b0;
            if (arb) begin
                cur_q   <= win;
                ptr_q   <= win + 2'd1;
                grant_q <= 4'b0001 << win;
                err_q   <= !len_ok;
            end
            case (state_q)
                START:   cnt_q <= CNT_W'(1);
                ADDR:    cnt_q <= (cnt_q == '0) ? CNT_W'(LEN_W - 1) : cnt_q - 1'b1;
                LEN:     cnt_q <= (cnt_q == '0) ? CNT_W'(len_q - 1'b1) : cnt_q - 1'b1;
                DATA:    cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Latched frame contents shift MSB-first while their field is on the line
    always_ff @(posedge clk) begin
        if (arb) begin
            data_q <= data_sel;
            len_q  <= len_sel;
            len_sh <= len_sel;
        end else begin
            if (state_q == LEN)  len_sh <= len_sh << 1;
            if (state_q == DATA) data_q <= data_q << 1;
        end
    end

    always_comb begin
        sout = 1'b1;
        case (state_q)
            START:   sout = 1'b0;
            ADDR:    sout = cnt_q[0] ? cur_q[1] : cur_q[0];
            LEN:     sout = len_sh[LEN_W-1];
            DATA:    sout = data_q[DATA_W-1];
            default: sout = 1'b1;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == STOP);
    assign grant = grant_q;
    assign err   = err_q;
    assign cur   = cur_q;

endmodule

// File: tb/tb_serial_frame_tx_arbiter.sv
// Bench for serial_frame_tx_arbiter: directed scenarios plus random traffic,
// all checked against a frame-queue reference model.
module tb_serial_frame_tx_arbiter;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [3:0]          req = '0;
    logic [4*DATA_W-1:0] data_in = '0;
    logic [4*LEN_W-1:0]  len_in = '0;
    logic [3:0]          grant;
    logic                busy;
    logic [1:0]          cur;
    logic                sout;
    logic                done;
    logic                err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_frame_tx_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .len_in(len_in),
        .grant(grant), .busy(busy), .cur(cur), .sout(sout), .done(done), .err(err)
    );

    wire [9:0] obs = {sout, busy, done, err, grant, cur};

    // Reference model: a queue of the line bits still to be sent for the
    // current frame; empty queue means the line is idle.
    bit         m_q[$];
    logic [1:0] m_ptr;
    logic [1:0] m_cur;
    logic [3:0] m_grant;
    logic       m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_ptr = 0; m_cur = 0; m_grant = 0; m_err = 0;
        end else begin : model_step
            int w, p, l;
            logic [DATA_W-1:0] d;
            m_grant = 0;
            m_err   = 0;
            if (m_q.size() != 0) begin
                void'(m_q.pop_front());
            end else if (req != 0) begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    p = (int'(m_ptr) + k) % 4;
                    if (w < 0 && req[p]) w = p;
                end
                l = int'(len_in[w*LEN_W +: LEN_W]);
                d = data_in[w*DATA_W +: DATA_W];
                m_cur   = w[1:0];
                m_ptr   = 2'((w + 1) % 4);
                m_grant = 4'(1 << w);
                if (l > DATA_W) begin
                    m_err = 1;
                end else begin
                    m_q.push_back(1'b0);
                    m_q.push_back(w[1]);
                    m_q.push_back(w[0]);
                    for (int i = LEN_W - 1; i >= 0; i--) m_q.push_back(l[i]);
                    for (int i = 0; i < l; i++) m_q.push_back(d[DATA_W-1-i]);
                    m_q.push_back(1'b1);
                end
            end
        end
    end

    function automatic logic [9:0] exp_vec();
        logic s;
        s = (m_q.size() != 0) ? m_q[0] : 1'b1;
        return {s, m_q.size() != 0, m_q.size() == 1, m_err, m_grant, m_cur};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs !== 10'b1000000000) begin
            bad++; $display("FAIL reset_async: got %b expected %b", obs, 10'b1000000000);
        end
        req = 4'b1111;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== 10'b1000000000) begin
            bad++; $display("FAIL reset_held: got %b expected %b", obs, 10'b1000000000);
        end
        req = '0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [10:0] exp_bits;
        exp_bits = 11'b01000111011;
        do_reset();
        data_in[2*DATA_W +: DATA_W] = 8'hA5;
        len_in[2*LEN_W +: LEN_W]    = 4'd3;
        req = 4'b0100;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (grant !== 4'b0100) begin
                    bad++; $display("FAIL single_grant: got %b expected 0100", grant);
                end
                req = '0;
            end
            total++;
            if ({sout, busy, done} !== {exp_bits[10-i], 1'b1, i == 10}) begin
                bad++;
                $display("FAIL single_bit%0d: got sout/busy/done %b%b%b expected %b%b%b",
                         i, sout, busy, done, exp_bits[10-i], 1'b1, i == 10);
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL single_model%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        total++;
        if (cur !== 2'd2) begin
            bad++; $display("FAIL single_cur: got %0d expected 2", cur);
        end
        @(negedge clk);
        total++;
        if ({busy, sout} !== 2'b01) begin
            bad++; $display("FAIL single_idle: got busy/sout %b%b expected 01", busy, sout);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] order [5];
        int gcount, last;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        gcount = 0;
        last   = -1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            len_in[i*LEN_W +: LEN_W]    = 4'd1;
            data_in[i*DATA_W +: DATA_W] = 8'($urandom);
        end
        req = 4'b1111;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL fair_model%0d: got %b expected %b", cyc, obs, exp_vec());
            end
            if (grant !== 4'b0000 && gcount < 5) begin
                total++;
                if (grant !== order[gcount]) begin
                    bad++; $display("FAIL fair_order%0d: got %b expected %b", gcount, grant, order[gcount]);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 10) begin
                        bad++; $display("FAIL fair_spacing%0d: got %0d expected 10", gcount, cyc - last);
                    end
                end
                last = cyc;
                gcount++;
            end
        end
        total++;
        if (gcount !== 5) begin
            bad++; $display("FAIL fair_count: got %0d expected 5", gcount);
        end
        req = '0;
    endtask

    task automatic test_zero_len();
        logic [7:0] exp_bits;
        exp_bits = 8'b00100001;
        do_reset();
        len_in[1*LEN_W +: LEN_W] = 4'd0;
        req = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) req = '0;
            total++;
            if ({sout, done} !== {exp_bits[7-i], i == 7}) begin
                bad++;
                $display("FAIL zero_bit%0d: got sout/done %b%b expected %b%b",
                         i, sout, done, exp_bits[7-i], i == 7);
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL zero_model%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_illegal();
        bit found;
        do_reset();
        len_in[0*LEN_W +: LEN_W]    = 4'd9;
        len_in[3*LEN_W +: LEN_W]    = 4'd2;
        data_in[3*DATA_W +: DATA_W] = 8'($urandom);
        req = 4'b1001;
        @(negedge clk);
        total++;
        if ({err, grant, sout, busy} !== 7'b1_0001_1_0) begin
            bad++; $display("FAIL illegal_reject: got err/grant/sout/busy %b expected 1000110", {err, grant, sout, busy});
        end
        req = 4'b1000;
        @(negedge clk);
        total++;
        if ({err, grant, sout, busy, cur} !== 9'b0_1000_0_1_11) begin
            bad++; $display("FAIL illegal_next: got %b expected 010000111", {err, grant, sout, busy, cur});
        end
        len_in[0*LEN_W +: LEN_W] = 4'd1;
        len_in[1*LEN_W +: LEN_W] = 4'd1;
        req = 4'b0011;
        found = 0;
        for (int i = 0; i < 15 && !found; i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL illegal_model%0d: got %b expected %b", i, obs, exp_vec());
            end
            if (grant !== 4'b0000) begin
                found = 1;
                total++;
                if (grant !== 4'b0001 || i !== 10) begin
                    bad++; $display("FAIL illegal_ptr: got grant %b at %0d expected 0001 at 10", grant, i);
                end
            end
        end
        if (!found) begin
            total++; bad++; $display("FAIL illegal_timeout: got no grant expected 0001");
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        len_in[2*LEN_W +: LEN_W]    = 4'd8;
        data_in[2*DATA_W +: DATA_W] = 8'($urandom);
        req = 4'b0100;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) req = '0;
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({sout, busy, grant, cur} !== 8'b1_0_0000_00) begin
            bad++; $display("FAIL mid_reset: got sout/busy/grant/cur %b expected 10000000", {sout, busy, grant, cur});
        end
        @(negedge clk);
        rst = 1'b1;
        len_in[1*LEN_W +: LEN_W] = 4'd2;
        len_in[3*LEN_W +: LEN_W] = 4'd2;
        req = 4'b1010;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin
            bad++; $display("FAIL mid_ptr: got %b expected 0010", grant);
        end
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL mid_model: got %b expected %b", obs, exp_vec());
        end
        req = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_late();
        do_reset();
        len_in[0*LEN_W +: LEN_W] = 4'd2;
        len_in[1*LEN_W +: LEN_W] = 4'd3;
        req = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL late_model%0d: got %b expected %b", k, obs, exp_vec());
            end
            if (k > 1 && k < 12) begin
                total++;
                if (grant !== 4'b0000) begin
                    bad++; $display("FAIL late_nogrant%0d: got %b expected 0000", k, grant);
                end
            end
            if (k == 12) begin
                total++;
                if ({grant, sout} !== 5'b0010_0) begin
                    bad++; $display("FAIL late_start: got grant/sout %b expected 00100", {grant, sout});
                end
            end
            if (k == 1) req = 4'b0000;
            if (k == 5) req = 4'b0010;
            if (k == 12) req = 4'b0000;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL rand_model%0d: got %b expected %b", cyc, obs, exp_vec());
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && grant[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    data_in[i*DATA_W +: DATA_W] = 8'($urandom);
                    len_in[i*LEN_W +: LEN_W]    = 4'($urandom_range(0, 10));
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_zero_len();
        test_illegal();
        test_reset_mid();
        test_late();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
